key_tx_queue: RTL

- Sits between the PS/2 keyboard path (scan code to ASCII converter) and the UART async_transmitter.
- Buffers keyboard characters so keystrokes arriving while the transmitter is busy are not lost.
- Expands cursor-key codes into VT100 escape sequences.
- Drives the transmitter's start/data inputs with a proper busy handshake.

---
 rtl/key_tx_queue.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/key_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module   : key_tx_queue
//  Purpose  : Keyboard-to-UART byte queue. Buffers ASCII keys in a FIFO,
//             expands cursor codes 0x80..0x83 into VT100 escape sequences
//             (ESC '[' 'A'..'D') and drives the async transmitter with a
//             start/busy handshake that cannot deadlock if busy is missed.
//  Options  : KEY_TX_CRLF_EN - when defined, a carriage return (0x0D) is
//             sent as the atomic pair 0x0D 0x0A.
//  Revision : 1.0 - initial release
// ============================================================================
module key_tx_queue #(
  parameter int DEPTH       = 16,  // FIFO entries, power of two, >= 2
  parameter int ACK_TIMEOUT = 4    // ack window after txStart, >= 2
) (
  input  logic       clk,
  input  logic       rst,        // asynchronous, active-low
  input  logic       keyValid,
  input  logic [7:0] keyCode,
  input  logic       txBusy,
  output logic       txStart,
  output logic [7:0] txData,
  output logic       full,
  output logic       empty,
  output logic [7:0] dropCount
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_AW:0]   c_DEPTH   = (c_AW + 1)'(DEPTH);
  // The START cycle is the first cycle of the ack window, so WAIT_ACK gives
  // up after ACK_TIMEOUT-1 further cycles without busy.
  localparam logic [c_TW-1:0] c_TO_EXIT = c_TW'(ACK_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]      r_mem [DEPTH];
  logic [c_AW:0]   r_wr_ptr;
  logic [c_AW:0]   r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            r_full;
  logic            r_empty;
  logic [7:0]      r_drop;

  // Transmit sequencer
  state_t          r_state;
  logic [7:0]      r_cur;
  logic [1:0]      r_seq;
  logic [c_TW-1:0] r_to;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;

  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic [c_AW:0]   w_wr_inc;
  logic [c_AW:0]   w_rd_inc;
  logic [c_AW:0]   w_wr_nxt;
  logic [c_AW:0]   w_rd_nxt;
  logic [c_AW:0]   w_count_nxt;
  logic            w_cursor;
  logic            w_crlf;
  logic [1:0]      w_steps;
  logic            w_last;
  logic [7:0]      w_byte;

  // A key arriving while full is lost even if a pop happens the same cycle.
  assign w_push = keyValid && (r_count != c_DEPTH);
  assign w_drop = keyValid && (r_count == c_DEPTH);
  assign w_pop  = (r_state == S_IDLE) && !r_empty && !txBusy;

  assign w_wr_inc = r_wr_ptr + 1'b1;
  assign w_rd_inc = r_rd_ptr + 1'b1;
  assign w_wr_nxt = (w_wr_inc == c_DEPTH) ? '0 : w_wr_inc;
  assign w_rd_nxt = (w_rd_inc == c_DEPTH) ? '0 : w_rd_inc;

  // Next occupancy from the push/pop pair
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  assign w_cursor = (r_cur[7:2] == 6'b100000);
`ifdef KEY_TX_CRLF_EN
  assign w_crlf   = (r_cur == 8'h0D);
`else
  assign w_crlf   = 1'b0;
`endif

  // Number of bytes the current code expands into
  always_comb begin
    w_steps = 2'd1;
    if (w_cursor)    w_steps = 2'd3;
    else if (w_crlf) w_steps = 2'd2;
  end

  assign w_last = (r_seq == (w_steps - 2'd1));

  // Byte to send for the current code and sequence step
  always_comb begin
    w_byte = r_cur;
    if (w_cursor) begin
      case (r_seq)
        2'd0:    w_byte = 8'h1B;
        2'd1:    w_byte = 8'h5B;
        default: w_byte = 8'h41 + {6'b000000, r_cur[1:0]};
      endcase
    end else if (w_crlf && (r_seq == 2'd1)) begin
      w_byte = 8'h0A;
    end
  end

  // FIFO data array; contents need no reset since occupancy guards reads
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= keyCode;
  end

  // FIFO pointers, occupancy, flags and saturating drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_drop   <= 8'h00;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_DEPTH);
      r_empty <= (w_count_nxt == '0);
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 1'b1;
    end
  end

  // Transmit sequencer with registered start/data outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cur      <= 8'h00;
      r_seq      <= 2'd0;
      r_to       <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx_start <= 1'b0;
          if (w_pop) begin
            r_cur   <= r_mem[r_rd_ptr[c_AW-1:0]];
            r_seq   <= 2'd0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_tx_data  <= w_byte;
          r_tx_start <= 1'b1;
          r_state    <= S_START;
        end
        S_START: begin
          r_tx_start <= 1'b0;
          r_to       <= '0;
          r_state    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (txBusy || (r_to == c_TO_EXIT)) r_state <= S_WAIT_DONE;
          else                               r_to    <= r_to + 1'b1;
        end
        S_WAIT_DONE: begin
          if (!txBusy) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_seq   <= r_seq + 2'd1;
              r_state <= S_LOAD;
            end
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign txStart   = r_tx_start;
  assign txData    = r_tx_data;
  assign full      = r_full;
  assign empty     = r_empty;
  assign dropCount = r_drop;

endmodule
`default_nettype wire
